// File: rtl/kbd_pkg.sv
// Shared types and constants for the keyboard MMIO slave.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int ST_NE      = 0;
  localparam int ST_OVF     = 1;
  localparam int ST_PERR    = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_CNT_LSB = 8;

  localparam logic SEL_DATA   = 1'b0;
  localparam logic SEL_STATUS = 1'b1;

endpackage

// File: rtl/kbd_mmio_ps2_rx.sv
// PS/2 receiver: pin synchronizers, ps2_clk glitch filter, frame FSM and
// inter-edge timeout. Emits one-cycle push/error pulses per completed frame.
module kbd_mmio_ps2_rx
  import kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       ui_clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       push,
  output logic       perr_evt,
  output logic       ferr_evt
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_reg;
  logic [1:0]    data_sync_reg;
  logic          filt_reg;
  logic [FW-1:0] filt_cnt_reg;
  logic          fall_reg;

  rx_state_t     state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] tmo_cnt_reg;
  logic          push_reg;
  logic          perr_reg;
  logic          ferr_reg;

  logic          din;
  assign din = data_sync_reg[1];

  // A new ps2_clk level is accepted only after FILTER_LEN consecutive samples.
  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
      filt_reg      <= 1'b1;
      filt_cnt_reg  <= '0;
      fall_reg      <= 1'b0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
      fall_reg      <= 1'b0;
      if (clk_sync_reg[1] == filt_reg) begin
        filt_cnt_reg <= '0;
      end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        filt_reg     <= clk_sync_reg[1];
        filt_cnt_reg <= '0;
        fall_reg     <= filt_reg;
      end else begin
        filt_cnt_reg <= filt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      tmo_cnt_reg <= '0;
      push_reg    <= 1'b0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      perr_reg <= 1'b0;
      ferr_reg <= 1'b0;
      if (state_reg == IDLE || fall_reg) tmo_cnt_reg <= '0;
      else                               tmo_cnt_reg <= tmo_cnt_reg + 1'b1;

      // A stalled partial frame is dropped silently; flags are left alone.
      if (state_reg != IDLE && !fall_reg && tmo_cnt_reg == TW'(TIMEOUT - 1)) begin
        state_reg <= IDLE;
      end else if (fall_reg) begin
        case (state_reg)
          IDLE: begin
            if (!din) begin
              state_reg   <= DATA;
              bit_cnt_reg <= '0;
            end
          end
          DATA: begin
            shift_reg   <= {din, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
          end
          PARITY: begin
            parity_reg <= din;
            state_reg  <= STOP;
          end
          STOP: begin
            state_reg <= IDLE;
            if (!din)                          ferr_reg <= 1'b1;
            else if (!(^{shift_reg, parity_reg})) perr_reg <= 1'b1;
            else                               push_reg <= 1'b1;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign rx_byte  = shift_reg;
  assign push     = push_reg;
  assign perr_evt = perr_reg;
  assign ferr_evt = ferr_reg;

endmodule

// File: rtl/kbd_mmio.sv
// Keyboard MMIO slave: scancode FIFO, sticky error flags and the
// edge-triggered DATA/STATUS read port for the CPU data-read mux.
module kbd_mmio
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        ui_clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        kbd_irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  rx_byte;
  logic        push;
  logic        perr_evt;
  logic        ferr_evt;

  kbd_mmio_ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .ui_clk  (ui_clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_byte (rx_byte),
    .push    (push),
    .perr_evt(perr_evt),
    .ferr_evt(ferr_evt)
  );

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          ovf_reg;
  logic          perr_reg;
  logic          ferr_reg;
  logic          rd_req_prev_reg;
  logic [31:0]   rd_data_reg;

  logic        rd_edge;
  logic        nonempty;
  logic        full;
  logic        pop;
  logic        store;
  logic        status_clr;
  logic [31:0] status_word;

  assign rd_edge    = rd_req && !rd_req_prev_reg;
  assign nonempty   = (count_reg != '0);
  assign full       = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign pop        = rd_edge && (rd_sel == SEL_DATA) && nonempty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign store      = push && (!full || pop);
  assign status_clr = rd_edge && (rd_sel == SEL_STATUS);

  always_comb begin
    status_word                        = '0;
    status_word[ST_NE]                 = nonempty;
    status_word[ST_OVF]                = ovf_reg;
    status_word[ST_PERR]               = perr_reg;
    status_word[ST_FERR]               = ferr_reg;
    status_word[ST_CNT_LSB +: 5]       = 5'(count_reg);
  end

  always_ff @(posedge ui_clk) begin
    if (store) mem[wr_ptr_reg] <= rx_byte;
  end

  always_ff @(posedge ui_clk) begin
    if (!rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      ovf_reg         <= 1'b0;
      perr_reg        <= 1'b0;
      ferr_reg        <= 1'b0;
      rd_req_prev_reg <= 1'b0;
      rd_data_reg     <= '0;
    end else begin
      rd_req_prev_reg <= rd_req;
      if (store) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({store, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      // Set events take priority over a clearing STATUS read.
      ovf_reg  <= (push && full && !pop) || (ovf_reg && !status_clr);
      perr_reg <= perr_evt || (perr_reg && !status_clr);
      ferr_reg <= ferr_evt || (ferr_reg && !status_clr);
      if (rd_edge) begin
        if (rd_sel == SEL_STATUS) rd_data_reg <= status_word;
        else if (nonempty)        rd_data_reg <= {24'h0, mem[rd_ptr_reg]};
        else                      rd_data_reg <= 32'h0;
      end
    end
  end

  assign rd_data = rd_data_reg;
  assign kbd_irq = nonempty;

endmodule

// File: tb/tb_kbd_mmio.sv
// Directed bench for kbd_mmio: table of single-frame vectors plus
// hand-written sequences for overflow, stalled reads, timeout and reset.
module tb_kbd_mmio;

  logic        ui_clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_req = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        kbd_irq;

  int checks = 0;
  int errors = 0;

  kbd_mmio #(
    .FIFO_DEPTH(16),
    .FILTER_LEN(8),
    .TIMEOUT   (300)
  ) dut (
    .ui_clk  (ui_clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rd_req  (rd_req),
    .rd_sel  (rd_sel),
    .rd_data (rd_data),
    .kbd_irq (kbd_irq)
  );

  always #5 ui_clk = ~ui_clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic        bad_par;
    logic        bad_stop;
    logic        exp_irq;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (20) @(negedge ui_clk);
    ps2_clk = 1'b0;
    repeat (40) @(negedge ui_clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge ui_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (20) @(negedge ui_clk);
  endtask

  task automatic do_read(input logic sel, output logic [31:0] v);
    @(negedge ui_clk);
    rd_sel = sel;
    rd_req = 1'b1;
    @(negedge ui_clk);
    v = rd_data;
    rd_req = 1'b0;
    @(negedge ui_clk);
  endtask

  logic [31:0] v;

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b1, 32'h0000_0101, 32'h0000_001C};
    vecs[1] = '{8'h1C, 1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000};
    vecs[2] = '{8'hA5, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000};
    vecs[3] = '{8'hF0, 1'b0, 1'b0, 1'b1, 32'h0000_0101, 32'h0000_00F0};
    vecs[4] = '{8'h00, 1'b0, 1'b0, 1'b1, 32'h0000_0101, 32'h0000_0000};

    repeat (4) @(negedge ui_clk);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_irq", {31'h0, kbd_irq}, 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge ui_clk);

    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop);
      check($sformatf("vec%0d_irq", i), {31'h0, kbd_irq}, {31'h0, vecs[i].exp_irq});
      do_read(1'b1, v);
      check($sformatf("vec%0d_status", i), v, vecs[i].exp_status);
      do_read(1'b0, v);
      check($sformatf("vec%0d_data", i), v, vecs[i].exp_data);
      do_read(1'b1, v);
      check($sformatf("vec%0d_status2", i), v, 32'h0);
      check($sformatf("vec%0d_irq_after", i), {31'h0, kbd_irq}, 32'h0);
    end

    // Overflow: 17 frames into a 16-entry FIFO.
    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0);
    do_read(1'b1, v);
    check("ovf_status", v, 32'h0000_1003);
    for (int i = 1; i <= 16; i++) begin
      do_read(1'b0, v);
      check($sformatf("ovf_data%0d", i), v, 32'(i));
    end
    do_read(1'b0, v);
    check("ovf_data_empty", v, 32'h0);
    do_read(1'b1, v);
    check("ovf_status_after", v, 32'h0);

    // Stalled read: one pop for a long rd_req pulse.
    send_frame(8'hAA, 1'b0, 1'b0);
    send_frame(8'hBB, 1'b0, 1'b0);
    @(negedge ui_clk);
    rd_sel = 1'b0;
    rd_req = 1'b1;
    repeat (20) @(negedge ui_clk);
    check("stall_data", rd_data, 32'h0000_00AA);
    rd_req = 1'b0;
    @(negedge ui_clk);
    do_read(1'b1, v);
    check("stall_status", v, 32'h0000_0101);
    do_read(1'b0, v);
    check("stall_data2", v, 32'h0000_00BB);

    // Timeout: partial frame then silence, then a clean frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    repeat (400) @(negedge ui_clk);
    send_frame(8'h5A, 1'b0, 1'b0);
    do_read(1'b1, v);
    check("tmo_status", v, 32'h0000_0101);
    do_read(1'b0, v);
    check("tmo_data", v, 32'h0000_005A);

    // Reset mid-frame with 3 entries queued.
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0);
    do_read(1'b0, v);
    check("rst_pre_data", v, 32'h0000_0011);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b0;
    @(negedge ui_clk);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_irq", {31'h0, kbd_irq}, 32'h0);
    rst = 1'b1;
    ps2_data = 1'b1;
    repeat (30) @(negedge ui_clk);
    do_read(1'b1, v);
    check("rst_status", v, 32'h0);
    send_frame(8'h3C, 1'b0, 1'b0);
    do_read(1'b0, v);
    check("rst_next_data", v, 32'h0000_003C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/kbd_mmio.md
# kbd_mmio

Keyboard MMIO slave for the 0xe0000000 region of the CPU data-address decode. It receives PS/2 frames from the keyboard pins and buffers validated scancodes in a FIFO. It returns scancodes and status words to the pipeline's data-read mux. It runs in the ui_clk domain, the same domain as the text-memory write logic.

## Interface
- FIFO_DEPTH, 16: scancode FIFO entries; must be a power of 2, ≥ 2.
- FILTER_LEN, 8: consecutive equal samples required to accept a new ps2_clk level.
- TIMEOUT, 50000: ui_clk cycles with no ps2_clk falling edge before a partial frame is discarded.
- ui_clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-low.
- ps2_clk, in, 1: raw keyboard clock pin (asynchronous).
- ps2_data, in, 1: raw keyboard data pin (asynchronous).
- rd_req, in, 1: level read request from the address decode (dmem_read_in && addr[29:26]==4'he). May stay high for many cycles during a stall.
- rd_sel, in, 1: word select, dmem_addr[0]. 0 = DATA, 1 = STATUS.
- rd_data, out, 32: registered read result.
- kbd_irq, out, 1: FIFO non-empty.

## Operation
- Input conditioning: 2-flop synchronizer on both pins. ps2_clk then goes through a FILTER_LEN stable-sample filter. A filtered 1→0 transition produces a one-cycle fall pulse. Data is sampled from the synchronized ps2_data on fall.
- Receiver FSM: IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on fall with data=0 (start bit), go to DATA and clear the bit counter. On fall with data=1, stay in IDLE.
  - DATA: shift 8 bits LSB first; after the 8th, go to PARITY.
  - PARITY: latch the bit; odd parity over data+parity is required.
  - STOP: on fall, if stop=1 and parity OK, emit push for one cycle with the byte.
    - Parity bad: set sticky PERR, no push.
    - Stop=0: set sticky FERR, no push.
    - Always return to IDLE.
- Timeout: in any non-IDLE state, a cycle counter resets on every fall. If it reaches TIMEOUT, go to IDLE, discard the partial frame, and leave the flags untouched.
- FIFO: FIFO_DEPTH entries with count width log2(FIFO_DEPTH)+1. Pointers wrap modulo FIFO_DEPTH.
- Read edge: a read occurs on the cycle where rd_req=1 and the previous rd_req=0. Each CPU access gives exactly one read regardless of stall length.
- DATA read (rd_sel=0):
  - Non-empty: rd_data = {24'h0, head}; pop.
  - Empty: rd_data = 32'h0; no pop.
- STATUS read (rd_sel=1): rd_data = {19'h0, count[4:0] at [12:8], 4'h0, FERR[3], PERR[2], OVF[1], nonempty[0]}. This read clears OVF, PERR and FERR in the same cycle. A flag-setting event in that same cycle wins, and the flag stays 1.
- Push and pop in the same cycle:
  - Non-empty: both happen; count is unchanged, including when full.
  - Empty: a DATA read returns 0, and the pushed byte is stored.
- Push while full without a pop: drop the byte and set OVF.
- rd_data holds its value until the next read edge.
- Reset (rst=0 at a ui_clk edge), including mid-frame:
  - FSM goes to IDLE; pointers, count, flags, timeout counter and previous rd_req all clear.
  - rd_data = 0, kbd_irq = 0.
  - Filter state is set to 1 (bus idle).

## Timing
- Pin to fall pulse: 2 (sync) + FILTER_LEN cycles after ps2_clk settles low.
- STOP fall to FIFO write: push occurs in the fall cycle; entry is visible and kbd_irq=1 the next cycle.
- Read latency: rd_data is valid one cycle after the rd_req rising edge. The pop takes effect in that same next cycle (count/irq updated).
- No combinational path from any input to any output.

## Structure
- Package kbd_pkg: rx_state_t enum (IDLE, DATA, PARITY, STOP); status bit indices ST_NE=0, ST_OVF=1, ST_PERR=2, ST_FERR=3, ST_CNT_LSB=8; SEL_DATA=0, SEL_STATUS=1.
- Sub-module ps2_rx: synchronizer, filter, FSM and timeout.
  - Outputs: byte[7:0], push, perr_evt, ferr_evt.
- FIFO, flags and read port live in kbd_mmio.

## Test plan
- Valid frame 0x1C (parity bit 0, stop 1) at a 12.5 kHz ps2_clk → after the stop bit kbd_irq=1. STATUS read = 32'h0000_0101. DATA read = 32'h0000_001C, then kbd_irq=0.
- Bad parity on 0x1C (parity bit 1) → no push. STATUS = 32'h0000_0004. A second STATUS read = 32'h0000_0000.
- 17 valid frames 0x01..0x11 with no reads → count=16, STATUS = 32'h0000_1003. Sixteen DATA reads return 0x01..0x10 in order; a 17th DATA read returns 0.
- rd_req held high for 20 cycles with the FIFO holding 0xAA, 0xBB → exactly one pop; rd_data = 0xAA, count = 1.
- Start bit plus 4 data bits, then ps2_clk idle for TIMEOUT cycles, then a full frame 0x5A → only 0x5A is queued; no flags set.
- rst=0 mid-frame with 3 entries queued → next cycle rd_data=0 and kbd_irq=0. After release, STATUS = 0. The next valid frame is received correctly.
